// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port, fixed-latency memory between the instruction fetch
// port (IF) and the data port (D) of a 5-stage pipeline. One access is in
// flight at a time: IDLE arbitrates, ISSUE pulses memEn, and WAIT counts down
// the memory latency and returns the read data with a one-cycle done pulse.
// The data port has priority. A starvation counter lets fetch win once it
// has lost STARVE_LIMIT grants in a row while it was requesting.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   ifReq/ifAddr        fetch request and byte address, held until ifDone
//   ifDone/ifRdata      fetch completion pulse and 32-bit instruction word
//   ifStall             ifReq & ~ifDone
//   dReq/dWe/dAddr/dWdata  data request, held until dDone
//   dDone/dRdata        data completion pulse and 64-bit load data
//   dStall              dReq & ~dDone
//   memEn/memWe         one-cycle access strobe and its write enable
//   memAddr/memWdata    latched access address and store data
//   memRdata            read data, valid LATENCY cycles after memEn
//
// States
//   IDLE  | no access in flight, arbitrate between IF and D
//   ISSUE | memEn pulse for the granted access, load the wait counter
//   WAIT  | count down the latency, done pulse when the counter is 1

module unified_mem_arbiter #(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifReq,
    input  logic [63:0] ifAddr,
    output logic        ifDone,
    output logic [31:0] ifRdata,
    output logic        ifStall,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [63:0] dAddr,
    input  logic [63:0] dWdata,
    output logic        dDone,
    output logic [63:0] dRdata,
    output logic        dStall,
    output logic        memEn,
    output logic        memWe,
    output logic [63:0] memAddr,
    output logic [63:0] memWdata,
    input  logic [63:0] memRdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  wait_cnt;
    logic [3:0]  starve_cnt;
    logic        owner_d;
    logic        we_q;
    logic [31:0] if_rdata_q;
    logic [63:0] d_rdata_q;

    logic        grant_if;
    logic        grant_d;
    logic        starved;
    logic        done_cycle;
    logic [31:0] if_word;
    logic [63:0] d_word;

    assign starved    = (starve_cnt == 4'(STARVE_LIMIT));
    assign grant_if   = (state == IDLE) && ifReq && (!dReq || starved);
    assign grant_d    = (state == IDLE) && dReq && !grant_if;
    assign done_cycle = (state == WAIT) && (wait_cnt == 3'd1);

    // Fetch returns the 32-bit half selected by address bit 2.
    assign if_word = memAddr[2] ? memRdata[63:32] : memRdata[31:0];
    assign d_word  = we_q ? 64'd0 : memRdata;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant_if || grant_d) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (done_cycle) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 3'd0;
            starve_cnt <= 4'd0;
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            memAddr    <= 64'd0;
            memWdata   <= 64'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 64'd0;
        end else begin
            state <= state_nx;

            if (grant_if || grant_d) begin
                owner_d  <= grant_d;
                we_q     <= grant_d && dWe;
                memAddr  <= grant_d ? dAddr : ifAddr;
                memWdata <= grant_d ? dWdata : 64'd0;
            end

            if (grant_if) begin
                starve_cnt <= 4'd0;
            end else if (grant_d && ifReq && !starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (state == ISSUE) begin
                wait_cnt <= 3'(LATENCY);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            if (done_cycle) begin
                if (owner_d) begin
                    d_rdata_q <= d_word;
                end else begin
                    if_rdata_q <= if_word;
                end
            end
        end
    end

    assign memEn   = (state == ISSUE);
    assign memWe   = memEn && we_q;
    assign ifDone  = done_cycle && !owner_d;
    assign dDone   = done_cycle && owner_d;
    // Data is passed through combinationally in the done cycle and held after.
    assign ifRdata = ifDone ? if_word : if_rdata_q;
    assign dRdata  = dDone ? d_word : d_rdata_q;
    assign ifStall = ifReq && !ifDone;
    assign dStall  = dReq && !dDone;

endmodule
